// File: rtl/i2c_slave_regfile.sv
// I2C target with a 256x8 register file and a host-side read port.
// Define I2CS_READ_EN to support read transactions (8'hBB); otherwise they are NACKed.
module i2c_slave_regfile #(
  parameter logic [6:0]  DEV_ADDR = 7'h5D,
  parameter int unsigned FILT_LEN = 4,
  parameter logic [7:0]  RST_VAL  = 8'h00
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic       iSCL,
  input  logic       iSDA,
  output logic       oSDA_OE,
  input  logic [7:0] iHOST_ADDR,
  output logic [7:0] oHOST_DATA,
  output logic       oWR_STB,
  output logic [7:0] oWR_ADDR,
  output logic [7:0] oWR_DATA,
  output logic       oBUSY
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_IGNORE,
    S_SUB, S_SUB_ACK, S_WDATA, S_WDATA_ACK,
    S_RDATA, S_RDATA_ACK
  } state_e;

  logic [1:0] scl_sync_q, scl_sync_d;
  logic [1:0] sda_sync_q, sda_sync_d;
  logic [3:0] scl_cnt_q, scl_cnt_d;
  logic [3:0] sda_cnt_q, sda_cnt_d;
  logic       scl_f_q, scl_f_d, sda_f_q, sda_f_d;
  logic       scl_p_q, scl_p_d, sda_p_q, sda_p_d;
  state_e     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       byte_rdy_q, byte_rdy_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] ptr_q, ptr_d;
  logic       oe_q, oe_d;
  logic       stb_q, stb_d;
  logic       busy_q, busy_d;
  logic [7:0] wa_q, wa_d, wd_q, wd_d;
  logic [7:0] hd_q, hd_d;
  logic [7:0] mem_q [256];
  logic       mem_we;
`ifdef I2CS_READ_EN
  logic       rw_q, rw_d;
`endif

  logic       scl_rise, scl_fall, start_c, stop_c;
  logic       rx, done, addr_ok;
  logic [7:0] nxt_ptr;

  // Level changes only after FILT_LEN consecutive differing samples.
  function automatic logic [4:0] filt_step(
    input logic       s,
    input logic       f,
    input logic [3:0] c
  );
    if (s == f)
      return {f, 4'd0};
    else if (c == 4'(FILT_LEN - 1))
      return {s, 4'd0};
    else
      return {f, c + 4'd1};
  endfunction

  assign scl_rise = scl_f_q & ~scl_p_q;
  assign scl_fall = ~scl_f_q & scl_p_q;
  assign start_c  = scl_f_q & scl_p_q & sda_p_q & ~sda_f_q;
  assign stop_c   = scl_f_q & scl_p_q & ~sda_p_q & sda_f_q;
  assign rx       = state_q inside {S_ADDR, S_SUB, S_WDATA};
  assign done     = scl_fall & byte_rdy_q;
  assign nxt_ptr  = ptr_q + 8'd1;
`ifdef I2CS_READ_EN
  assign addr_ok  = (shift_q[7:1] == DEV_ADDR);
`else
  assign addr_ok  = (shift_q[7:1] == DEV_ADDR) & ~shift_q[0];
`endif

  always_comb begin
    scl_sync_d = {scl_sync_q[0], iSCL};
    sda_sync_d = {sda_sync_q[0], iSDA};
    {scl_f_d, scl_cnt_d} = filt_step(scl_sync_q[1], scl_f_q, scl_cnt_q);
    {sda_f_d, sda_cnt_d} = filt_step(sda_sync_q[1], sda_f_q, sda_cnt_q);
    scl_p_d    = scl_f_q;
    sda_p_d    = sda_f_q;
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    byte_rdy_d = byte_rdy_q;
    shift_d    = shift_q;
    ptr_d      = ptr_q;
    oe_d       = oe_q;
    stb_d      = 1'b0;
    busy_d     = busy_q;
    wa_d       = wa_q;
    wd_d       = wd_q;
    hd_d       = mem_q[iHOST_ADDR];
    mem_we     = 1'b0;
`ifdef I2CS_READ_EN
    rw_d       = rw_q;
`endif
    if (stop_c) begin
      state_d = S_IDLE;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else if (start_c) begin
      state_d    = S_ADDR;
      oe_d       = 1'b0;
      busy_d     = 1'b1;
      bit_cnt_d  = 3'd0;
      byte_rdy_d = 1'b0;
    end else begin
      if (scl_rise && (rx || state_q == S_RDATA)) begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) byte_rdy_d = 1'b1;
        if (rx) shift_d = {shift_q[6:0], sda_f_q};
      end
      unique case (state_q)
        S_ADDR: if (done) begin
          byte_rdy_d = 1'b0;
          if (addr_ok) begin
            oe_d    = 1'b1;
            state_d = S_ADDR_ACK;
`ifdef I2CS_READ_EN
            rw_d    = shift_q[0];
`endif
          end else begin
            state_d = S_IGNORE;
          end
        end
        S_ADDR_ACK: if (scl_fall) begin
          oe_d    = 1'b0;
          state_d = S_SUB;
`ifdef I2CS_READ_EN
          if (rw_q) begin
            state_d = S_RDATA;
            shift_d = mem_q[ptr_q];
            oe_d    = ~mem_q[ptr_q][7];
          end
`endif
        end
        S_SUB: if (done) begin
          byte_rdy_d = 1'b0;
          ptr_d      = shift_q;
          oe_d       = 1'b1;
          state_d    = S_SUB_ACK;
        end
        S_SUB_ACK: if (scl_fall) begin
          oe_d    = 1'b0;
          state_d = S_WDATA;
        end
        S_WDATA: if (done) begin
          byte_rdy_d = 1'b0;
          oe_d       = 1'b1;
          mem_we     = 1'b1;
          stb_d      = 1'b1;
          wa_d       = ptr_q;
          wd_d       = shift_q;
          ptr_d      = nxt_ptr;
          state_d    = S_WDATA_ACK;
        end
        S_WDATA_ACK: if (scl_fall) begin
          oe_d    = 1'b0;
          state_d = S_WDATA;
        end
`ifdef I2CS_READ_EN
        S_RDATA: if (scl_fall) begin
          if (byte_rdy_q) begin
            byte_rdy_d = 1'b0;
            oe_d       = 1'b0;
            state_d    = S_RDATA_ACK;
          end else begin
            shift_d = {shift_q[6:0], 1'b0};
            oe_d    = ~shift_q[6];
          end
        end
        // byte_rdy doubles as the "master ACKed" flag here.
        S_RDATA_ACK: if (scl_rise) begin
          if (sda_f_q) state_d = S_IGNORE;
          else         byte_rdy_d = 1'b1;
        end else if (done) begin
          byte_rdy_d = 1'b0;
          ptr_d      = nxt_ptr;
          shift_d    = mem_q[nxt_ptr];
          oe_d       = ~mem_q[nxt_ptr][7];
          state_d    = S_RDATA;
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_cnt_q  <= 4'd0;
      sda_cnt_q  <= 4'd0;
      scl_f_q    <= 1'b1;
      sda_f_q    <= 1'b1;
      scl_p_q    <= 1'b1;
      sda_p_q    <= 1'b1;
      state_q    <= S_IDLE;
      bit_cnt_q  <= 3'd0;
      byte_rdy_q <= 1'b0;
      shift_q    <= 8'd0;
      ptr_q      <= 8'd0;
      oe_q       <= 1'b0;
      stb_q      <= 1'b0;
      busy_q     <= 1'b0;
      wa_q       <= 8'd0;
      wd_q       <= 8'd0;
      hd_q       <= 8'd0;
`ifdef I2CS_READ_EN
      rw_q       <= 1'b0;
`endif
      for (int i = 0; i < 256; i++) mem_q[i] <= RST_VAL;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_cnt_q  <= scl_cnt_d;
      sda_cnt_q  <= sda_cnt_d;
      scl_f_q    <= scl_f_d;
      sda_f_q    <= sda_f_d;
      scl_p_q    <= scl_p_d;
      sda_p_q    <= sda_p_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_rdy_q <= byte_rdy_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      oe_q       <= oe_d;
      stb_q      <= stb_d;
      busy_q     <= busy_d;
      wa_q       <= wa_d;
      wd_q       <= wd_d;
      hd_q       <= hd_d;
`ifdef I2CS_READ_EN
      rw_q       <= rw_d;
`endif
      if (mem_we) mem_q[ptr_q] <= shift_q;
    end
  end

  assign oSDA_OE    = oe_q;
  assign oHOST_DATA = hd_q;
  assign oWR_STB    = stb_q;
  assign oWR_ADDR   = wa_q;
  assign oWR_DATA   = wd_q;
  assign oBUSY      = busy_q;

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Bench for i2c_slave_regfile: bit-banged I2C master, write scoreboard,
// table of host-port reads.
`timescale 1ns/1ps
module tb_i2c_slave_regfile;

  localparam int Q = 20;

  logic       iCLK = 1'b0;
  logic       iRST = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       glitch = 1'b0;
  logic [7:0] iHOST_ADDR = 8'h00;
  logic       iSCL, iSDA, sda_bus;
  logic       oSDA_OE, oWR_STB, oBUSY;
  logic [7:0] oHOST_DATA, oWR_ADDR, oWR_DATA;

  assign sda_bus = sda_m & ~oSDA_OE;
  assign iSDA    = sda_bus;
  assign iSCL    = scl_m | glitch;

  i2c_slave_regfile dut (
    .iCLK      (iCLK),
    .iRST      (iRST),
    .iSCL      (iSCL),
    .iSDA      (iSDA),
    .oSDA_OE   (oSDA_OE),
    .iHOST_ADDR(iHOST_ADDR),
    .oHOST_DATA(oHOST_DATA),
    .oWR_STB   (oWR_STB),
    .oWR_ADDR  (oWR_ADDR),
    .oWR_DATA  (oWR_DATA),
    .oBUSY     (oBUSY)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] exp;
  } hv_t;

  int   checks = 0;
  int   errors = 0;
  wr_t  wr_q[$];
  wr_t  mon_e;
  bit   sda_drv = 1'b0;
  hv_t  hv[8];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge iCLK);
  endtask

  always @(negedge iCLK) begin
    if (oSDA_OE) sda_drv = 1'b1;
    if (oWR_STB) begin
      if (wr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wr_stb: unexpected write addr %0h data %0h",
                 oWR_ADDR, oWR_DATA);
      end else begin
        mon_e = wr_q.pop_front();
        chk("wr_addr", oWR_ADDR, mon_e.addr);
        chk("wr_data", oWR_DATA, mon_e.data);
      end
    end
  end

  task automatic i2c_start();
    sda_m = 1'b1; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    sda_m = 1'b1; wait_clk(Q);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n,
                           input bit glitch_en);
    for (int i = 7; i > 7 - n; i--) begin
      sda_m = b[i];
      if (glitch_en && i == 3) begin
        wait_clk(5);
        glitch = 1'b1;
        wait_clk(1);
        glitch = 1'b0;
        wait_clk(Q - 6);
      end else begin
        wait_clk(Q);
      end
      scl_m = 1'b1; wait_clk(2 * Q);
      scl_m = 1'b0; wait_clk(Q);
    end
  endtask

  task automatic send(input logic [7:0] b, input logic exp_ack,
                      input bit glitch_en, input string nm);
    logic a;
    send_bits(b, 8, glitch_en);
    sda_m = 1'b1; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    a = sda_bus;  wait_clk(Q);
    scl_m = 1'b0; wait_clk(Q);
    chk(nm, a, exp_ack);
  endtask

  task automatic rd_byte(input logic mack, output logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      scl_m = 1'b1; wait_clk(Q);
      b[i] = sda_bus; wait_clk(Q);
      scl_m = 1'b0; wait_clk(Q);
    end
    sda_m = mack; wait_clk(Q);
    scl_m = 1'b1; wait_clk(2 * Q);
    scl_m = 1'b0; wait_clk(Q);
    sda_m = 1'b1;
  endtask

  task automatic host_rd(input logic [7:0] a, input logic [7:0] exp,
                         input string nm);
    @(negedge iCLK) iHOST_ADDR = a;
    @(negedge iCLK);
    chk(nm, oHOST_DATA, exp);
  endtask

  task automatic push_wr(input logic [7:0] a, input logic [7:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    wr_q.push_back(e);
  endtask

  initial begin
    logic [7:0] rb;
    hv[0] = '{8'h0D, 8'h47};
    hv[1] = '{8'hFE, 8'h11};
    hv[2] = '{8'hFF, 8'h22};
    hv[3] = '{8'h00, 8'h33};
    hv[4] = '{8'h20, 8'h5A};
    hv[5] = '{8'h10, 8'hA5};
    hv[6] = '{8'h11, 8'h3C};
    hv[7] = '{8'h0C, 8'h00};

    wait_clk(3);
    chk("rst_sda_oe", oSDA_OE, 1'b0);
    chk("rst_wr_stb", oWR_STB, 1'b0);
    chk("rst_wr_addr", oWR_ADDR, 8'h00);
    chk("rst_wr_data", oWR_DATA, 8'h00);
    chk("rst_busy", oBUSY, 1'b0);
    chk("rst_host", oHOST_DATA, 8'h00);
    iRST = 1'b0;
    wait_clk(5);

    // single write
    i2c_start();
    chk("busy_start", oBUSY, 1'b1);
    send(8'hBA, 1'b0, 1'b0, "ack_addr");
    send(8'h0D, 1'b0, 1'b0, "ack_sub");
    push_wr(8'h0D, 8'h47);
    send(8'h47, 1'b0, 1'b0, "ack_data");
    i2c_stop();
    chk("busy_stop", oBUSY, 1'b0);
    host_rd(8'h0D, 8'h47, "host_0d");

    // wrong address
    sda_drv = 1'b0;
    i2c_start();
    send(8'hB8, 1'b1, 1'b0, "nack_addr");
    send(8'h0D, 1'b1, 1'b0, "nack_sub");
    send(8'h47, 1'b1, 1'b0, "nack_data");
    i2c_stop();
    chk("never_driven", sda_drv, 1'b0);

    // burst with pointer wrap
    i2c_start();
    send(8'hBA, 1'b0, 1'b0, "burst_addr");
    send(8'hFE, 1'b0, 1'b0, "burst_sub");
    push_wr(8'hFE, 8'h11);
    send(8'h11, 1'b0, 1'b0, "burst_d0");
    push_wr(8'hFF, 8'h22);
    send(8'h22, 1'b0, 1'b0, "burst_d1");
    push_wr(8'h00, 8'h33);
    send(8'h33, 1'b0, 1'b0, "burst_d2");
    i2c_stop();

    // preload for reads
    i2c_start();
    send(8'hBA, 1'b0, 1'b0, "pre_addr");
    send(8'h10, 1'b0, 1'b0, "pre_sub");
    push_wr(8'h10, 8'hA5);
    send(8'hA5, 1'b0, 1'b0, "pre_d0");
    push_wr(8'h11, 8'h3C);
    send(8'h3C, 1'b0, 1'b0, "pre_d1");
    i2c_stop();

    i2c_start();
    send(8'hBA, 1'b0, 1'b0, "rd_waddr");
    send(8'h10, 1'b0, 1'b0, "rd_sub");
    i2c_start();
`ifdef I2CS_READ_EN
    send(8'hBB, 1'b0, 1'b0, "rd_addr_ack");
    rd_byte(1'b0, rb);
    chk("rd_byte0", rb, 8'hA5);
    rd_byte(1'b1, rb);
    chk("rd_byte1", rb, 8'h3C);
    wait_clk(Q);
    chk("rd_released", oSDA_OE, 1'b0);
`else
    send(8'hBB, 1'b1, 1'b0, "rd_addr_nack");
    rb = 8'h00;
`endif
    i2c_stop();

    // SCL glitch during a data bit
    i2c_start();
    send(8'hBA, 1'b0, 1'b0, "gl_addr");
    send(8'h20, 1'b0, 1'b0, "gl_sub");
    push_wr(8'h20, 8'h5A);
    send(8'h5A, 1'b0, 1'b1, "gl_data");
    i2c_stop();

    for (int i = 0; i < 8; i++)
      host_rd(hv[i].addr, hv[i].exp, $sformatf("host_tbl%0d", i));

    // reset after 4 data bits
    i2c_start();
    send(8'hBA, 1'b0, 1'b0, "rst_addr");
    send(8'h30, 1'b0, 1'b0, "rst_sub");
    send_bits(8'hFF, 4, 1'b0);
    sda_m = 1'b1;
    wait_clk(Q);
    iRST = 1'b1;
    wait_clk(1);
    chk("mid_rst_oe", oSDA_OE, 1'b0);
    chk("mid_rst_busy", oBUSY, 1'b0);
    iRST = 1'b0;
    wait_clk(Q);
    i2c_stop();

    // reset while the target is driving ACK
    i2c_start();
    send_bits(8'hBA, 8, 1'b0);
    sda_m = 1'b1;
    wait_clk(Q);
    chk("ack_driven", oSDA_OE, 1'b1);
    iRST = 1'b1;
    wait_clk(1);
    chk("ack_rst_oe", oSDA_OE, 1'b0);
    iRST = 1'b0;
    wait_clk(Q);
    i2c_stop();

    // recovery transaction
    i2c_start();
    send(8'hBA, 1'b0, 1'b0, "rec_addr");
    send(8'h40, 1'b0, 1'b0, "rec_sub");
    push_wr(8'h40, 8'h77);
    send(8'h77, 1'b0, 1'b0, "rec_data");
    i2c_stop();
    host_rd(8'h40, 8'h77, "host_40");
    host_rd(8'h30, 8'h00, "host_30");
    host_rd(8'h0D, 8'h00, "host_0d_clr");

    wait_clk(5);
    chk("wr_pending", wr_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_slave_regfile.md
Name: i2c_slave_regfile

Overview:
- I2C target (responder) with an internal 256x8 register file, driven by an external or FPGA-internal I2C master issuing [SLAVE_ADDR, SUB_ADDR, DATA...] transactions.
- Used to model the video decoder in simulation and to expose FPGA configuration registers over the same bus the I2C configuration master drives.
- Oversamples SCL/SDA on the system clock; drives SDA open-drain.

Parameters:
- DEV_ADDR, 7'h5D, 7-bit target address. Write byte is 8'hBA, read byte is 8'hBB.
- FILT_LEN, 4, number of consecutive equal synchronized samples required before a filtered SCL/SDA level changes (1..15).
- RST_VAL, 8'h00, reset value of every register-file entry.

Ports:
- iCLK, input, 1, system clock; all logic on its rising edge.
- iRST, input, 1, synchronous active-high reset.
- iSCL, input, 1, I2C clock from the bus (asynchronous).
- iSDA, input, 1, I2C data from the bus (asynchronous).
- oSDA_OE, output, 1, 1 = pull SDA low; 0 = release SDA (high-Z at pad).
- iHOST_ADDR, input, 8, host-side read address into the register file.
- oHOST_DATA, output, 8, registered, reg[iHOST_ADDR] one cycle later.
- oWR_STB, output, 1, one-cycle pulse when a byte is written over I2C.
- oWR_ADDR, output, 8, register address of the last I2C write; valid with oWR_STB.
- oWR_DATA, output, 8, data of the last I2C write; valid with oWR_STB.
- oBUSY, output, 1, high from START until STOP.

Behaviour:
- Reset values:
  - oSDA_OE=0, oWR_STB=0, oWR_ADDR=0, oWR_DATA=0, oBUSY=0, oHOST_DATA=0.
  - All register entries = RST_VAL; sub-address pointer = 0; FSM = IDLE.
  - Filtered SCL/SDA = 1; synchronizers = 1.
- Input conditioning:
  - 2-FF synchronizer per line, then a FILT_LEN-sample glitch filter.
  - All events below refer to filtered levels.
- Bus conditions (filtered SCL high):
  - START = SDA falling; STOP = SDA rising.
  - A START in any state (repeated start) aborts the current byte, enters ADDR, releases SDA, and keeps the pointer.
  - STOP in any state: go to IDLE, release SDA, oBUSY=0.
- Bit timing:
  - Sample SDA on filtered SCL rising edge, MSB first.
  - Change oSDA_OE only on filtered SCL falling edge.
  - 3-bit bit counter.
- FSM:
  - IDLE: wait for START -> ADDR.
  - ADDR: shift in 8 bits; on 8th SCL falling edge:
    - if [7:1]==DEV_ADDR, drive ACK (oSDA_OE=1) -> ADDR_ACK;
    - otherwise -> IGNORE (SDA released until STOP/START).
  - ADDR_ACK: on the next SCL falling edge release SDA; R/W=0 -> SUB, R/W=1 -> RDATA, loading reg[ptr] into the shifter and driving its MSB.
  - SUB: 8 bits into the pointer; ACK -> SUB_ACK -> WDATA.
  - WDATA: 8 bits; on the 8th SCL falling edge:
    - drive ACK, write reg[ptr];
    - pulse oWR_STB for exactly one iCLK with oWR_ADDR=ptr and oWR_DATA=byte;
    - ptr+1 (8-bit wrap, 0xFF -> 0x00) -> WDATA_ACK -> WDATA.
  - RDATA: oSDA_OE = ~shift[7] per bit. After 8 bits release SDA -> RDATA_ACK, then sample the master ACK on SCL rising:
    - ACK (0): ptr+1 (wrap), load next byte -> RDATA;
    - NACK (1): -> IGNORE.
- The host read port is independent of I2C activity. A same-cycle I2C write to the same address returns the old data.
- Reset asserted mid-transaction: SDA is released in the same cycle as reset is sampled, and no partial write occurs.

Optional Feature:
- I2CS_READ_EN
  - Defined: read transactions are supported as above.
  - Undefined: the read address byte (8'hBB) is NACKed (-> IGNORE), the RDATA/RDATA_ACK logic is not compiled, and writes are unchanged.

Test Plan:
- Write BA,0D,47,STOP -> ACK at 3 slots; oWR_STB once with oWR_ADDR=0x0D, oWR_DATA=0x47; host read of 0x0D returns 0x47.
- Write B8,0D,47 -> no ACK on the address, SDA never driven, no oWR_STB, reg[0x0D] unchanged.
- Burst BA,FE,11,22,33 -> reg[0xFE]=0x11, reg[0xFF]=0x22, reg[0x00]=0x33 (wrap); 3 oWR_STB pulses.
- (I2CS_READ_EN) BA,10,Sr,BB, read 2 bytes with master ACK then NACK, after preloading reg[0x10]=0xA5 and reg[0x11]=0x3C -> SDA returns 0xA5 then 0x3C, released after the NACK.
- 1-sample SCL glitch (< FILT_LEN) during a data bit -> no extra bit counted, byte received correctly.
- iRST asserted after 4 data bits of WDATA -> oSDA_OE=0 next cycle, no write, FSM in IDLE; the next full transaction succeeds.
